add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 13 +
 rtl/add_arbiter_carry_select.sv | 33 +++
 rtl/add_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated adder: FSM encoding and
// the width of the completed-response counter.
package add_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OPCNT_W = 16;

endpackage

// File: rtl/add_arbiter_carry_select.sv
// Carry-select adder built from 4-bit groups: each group precomputes its sum
// for both carry-in values and the incoming carry picks one.
module carry_select #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = WIDTH / 4;

  logic [4:0] s0;
  logic [4:0] s1;
  logic       carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    s0    = '0;
    s1    = '0;
    for (int g = 0; g < NG; g++) begin
      s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
      s1 = s0 + 5'd1;
      sum[4*g +: 4] = carry ? s1[3:0] : s0[3:0];
      carry = carry ? s1[4] : s0[4];
    end
    cout = carry;
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter in front of one shared adder: grants one requester in
// IDLE, adds its latched operands in EXEC, and holds the result in RESP.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy,
  output logic [OPCNT_W-1:0]    op_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on anything but state, rr_ptr and valid,
  // and the response holds id/sum/cout steady until it is taken.

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_next;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             accept;
  logic             rsp_fire;
  int               pos;

  // Single round-robin search starting at rr_ptr and wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!grant_found && req_valid[pos]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(pos);
      end
    end
  end

  assign rr_next   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign accept    = (state == IDLE) && grant_found;
  assign rsp_fire  = (state == RESP) && rsp_ready;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  carry_select #(.WIDTH(WIDTH)) u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
      op_cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a   <= req_a[grant_idx*WIDTH +: WIDTH];
        op_b   <= req_b[grant_idx*WIDTH +: WIDTH];
        op_id  <= grant_idx;
        rr_ptr <= rr_next;
      end
      if (state == EXEC) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        rsp_id   <= op_id;
      end
      if (rsp_fire && (op_cnt != '1)) op_cnt <= op_cnt + 1'b1;
    end
  end

endmodule
